// File: rtl/pll_supervisor.sv
// Bring-up sequencer for the board PLL: timed reset, lock wait with retry,
// lock qualification, downstream reset release and phase-shift arbitration.
module pll_supervisor #(
  parameter int RST_CYCLES          = 50,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int RETRY_MAX           = 3,
  parameter int SETTLE_CYCLES       = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic [3:0] pll_psda_o,
  output logic [3:0] pll_dutyda_o,
  input  logic       ps_req_i,
  input  logic [3:0] ps_val_i,
  output logic       ps_ack_o,
  output logic       clk_ready_o,
  output logic       sys_rst_o,
  output logic       lock_loss_o,
  output logic       fault_o
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > SETTLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int RW      = $clog2(RETRY_MAX + 1) + 1;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_PS_SETTLE,
    ST_FAULT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retries;
  logic          r_lock_meta;
  logic          r_lock_s;
  logic          r_pll_reset;
  logic [3:0]    r_psda;
  logic [3:0]    r_dutyda;
  logic          r_ack;
  logic          r_ready;
  logic          r_sys_rst;
  logic          r_loss;
  logic          r_fault;

  // Two-flop synchronizer: the only place the asynchronous lock is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Sequencer with registered outputs; the shared counter restarts on every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RESET_PLL;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_pll_reset <= 1'b1;
      r_psda      <= 4'h0;
      r_dutyda    <= 4'b1000;
      r_ack       <= 1'b0;
      r_ready     <= 1'b0;
      r_sys_rst   <= 1'b1;
      r_loss      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_ack    <= 1'b0;
      r_loss   <= 1'b0;
      r_dutyda <= 4'b1000;
      case (r_state)
        ST_RESET_PLL: begin
          r_pll_reset <= 1'b1;
          if (r_cnt == CW'(RST_CYCLES - 1)) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_retries < RW'(RETRY_MAX)) begin
              r_retries <= r_retries + RW'(1);
              r_state   <= ST_RESET_PLL;
            end else begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STABLE: begin
          // A dropout only restarts the lock wait; it does not cost a retry.
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            r_state   <= ST_READY;
            r_cnt     <= '0;
            r_retries <= '0;
            r_ready   <= 1'b1;
            r_sys_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_READY: begin
          if (!r_lock_s) begin
            r_state     <= ST_RESET_PLL;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_sys_rst   <= 1'b1;
            r_loss      <= 1'b1;
          end else if (ps_req_i) begin
            r_psda  <= ps_val_i;
            r_state <= ST_PS_SETTLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= '0;
          end
        end
        ST_PS_SETTLE: begin
          // The new phase value is kept even if lock is lost mid-settle.
          if (!r_lock_s) begin
            r_state     <= ST_RESET_PLL;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_sys_rst   <= 1'b1;
            r_loss      <= 1'b1;
          end else if (r_cnt == CW'(SETTLE_CYCLES)) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_FAULT: begin
          r_pll_reset <= 1'b1;
          r_fault     <= 1'b1;
          r_sys_rst   <= 1'b1;
          r_ready     <= 1'b0;
        end
        default: begin
          r_state     <= ST_FAULT;
          r_cnt       <= '0;
          r_pll_reset <= 1'b1;
          r_fault     <= 1'b1;
          r_sys_rst   <= 1'b1;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset_o  = r_pll_reset;
  assign pll_psda_o   = r_psda;
  assign pll_dutyda_o = r_dutyda;
  assign ps_ack_o     = r_ack;
  assign clk_ready_o  = r_ready;
  assign sys_rst_o    = r_sys_rst;
  assign lock_loss_o  = r_loss;
  assign fault_o      = r_fault;

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequencing controller for the board PLL (`Gowin_rPLL`: 50 MHz in, divided system clock out). It runs on the 50 MHz input clock, so it works while the PLL is unlocked. It does four things:
- holds the PLL in reset for a defined time and waits for LOCK, retrying on timeout;
- qualifies lock stability, then releases the downstream system reset;
- drives the dynamic phase (PSDA) and duty (DUTYDA) controls;
- arbitrates phase-shift requests with a settle window.

## Interface
Parameters:
- `RST_CYCLES`, 50: cycles `pll_reset_o` is held high per attempt (1 µs).
- `LOCK_STABLE_CYCLES`, 5000: consecutive synchronized-lock cycles required before ready (100 µs).
- `LOCK_TIMEOUT_CYCLES`, 500000: cycles allowed in WAIT_LOCK before a retry (10 ms).
- `RETRY_MAX`, 3: timeouts tolerated before FAULT.
- `SETTLE_CYCLES`, 250: post-phase-change settle window.

Ports:
- `clk`  in  1  50 MHz PLL input clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `pll_lock_i`  in  1  PLL LOCK; asynchronous to `clk`.
- `pll_reset_o`  out  1  PLL RESET.
- `pll_psda_o`  out  4  PLL PSDA.
- `pll_dutyda_o`  out  4  PLL DUTYDA.
- `ps_req_i`  in  1  level phase-shift request.
- `ps_val_i`  in  4  requested PSDA value.
- `ps_ack_o`  out  1  one-cycle pulse: shift applied and settled.
- `clk_ready_o`  out  1  PLL output qualified.
- `sys_rst_o`  out  1  downstream reset, active high.
- `lock_loss_o`  out  1  one-cycle pulse on loss of lock while ready.
- `fault_o`  out  1  sticky: retries exhausted.

## Operation
- Clocking and reset: one clock (`clk`); reset is synchronous and active-high (`rst`).
- All outputs are registered.
- Reset values:
  - `pll_reset_o`=1, `pll_psda_o`=0, `pll_dutyda_o`=4'b1000;
  - `ps_ack_o`=0, `clk_ready_o`=0, `sys_rst_o`=1, `lock_loss_o`=0, `fault_o`=0;
  - state=RESET_PLL, counter=0, retries=0, lock synchronizer=00.
- `pll_lock_i` passes through a 2-flop synchronizer (`lock_s`). Nothing else samples `pll_lock_i`.
- One shared counter, width `$clog2` of the largest count parameter plus 1. It is cleared on every state transition.
- States:
  - **RESET_PLL**: `pll_reset_o`=1; after `RST_CYCLES` cycles go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_reset_o`=0.
    - `lock_s`=1: go to STABLE.
    - Counter reaches `LOCK_TIMEOUT_CYCLES` with no lock: if retries<`RETRY_MAX`, increment retries and go to RESET_PLL; else go to FAULT.
  - **STABLE**: counter counts cycles with `lock_s`=1.
    - `lock_s`=0 at any point: go to WAIT_LOCK. Retries are not incremented and the timeout restarts.
    - `LOCK_STABLE_CYCLES` reached: go to READY and clear retries.
  - **READY**: `clk_ready_o`=1, `sys_rst_o`=0.
    - `lock_s`=0: go to RESET_PLL; `clk_ready_o`→0, `sys_rst_o`→1, `lock_loss_o` pulses 1 cycle.
    - Else if `ps_req_i`=1: latch `ps_val_i` into `pll_psda_o` and go to PS_SETTLE.
  - **PS_SETTLE**: `clk_ready_o` stays 1.
    - After `SETTLE_CYCLES` cycles: pulse `ps_ack_o` and go to READY.
    - `lock_s`=0 during settle: same as loss in READY, with no ack. `pll_psda_o` keeps the new value.
  - **FAULT**: `pll_reset_o`=1, `fault_o`=1, `sys_rst_o`=1. Terminal until `rst`.
- Phase-shift handshake:
  - `ps_req_i` is sampled only in READY; requests in other states wait, held by the requester.
  - `ps_val_i` must be stable while `ps_req_i` is high.
  - The requester drops `ps_req_i` in the cycle it sees `ps_ack_o`. A request still high in the cycle after the ack starts a new shift.
  - Lock loss beats a simultaneous request.
- `pll_dutyda_o` is constant 4'b1000 (50 % duty). It is exposed so the PLL dynamic-DA path is fully driven from one place.
- `rst` asserted mid-operation, in any state, restores the reset values on the next edge, including clearing `fault_o` and `pll_psda_o`.

## Timing
- `pll_reset_o` is high for exactly `RST_CYCLES` clocks after `rst` deasserts, then low.
- A `pll_lock_i` rise reaches `lock_s` after 2 clocks.
- `clk_ready_o` and `sys_rst_o` change `LOCK_STABLE_CYCLES`+3 clocks after a steady `pll_lock_i` rise.
- A `pll_lock_i` fall in READY: `clk_ready_o`=0, `sys_rst_o`=1, `lock_loss_o`=1 and `pll_reset_o`=1 all appear 3 clocks later, in the same cycle.
- `pll_psda_o` updates 1 clock after `ps_req_i` is sampled in READY. `ps_ack_o` pulses `SETTLE_CYCLES`+1 clocks after that.
- Worst-case time to FAULT: (`RETRY_MAX`+1)×(`RST_CYCLES`+`LOCK_TIMEOUT_CYCLES`) clocks, plus at most 2.

## Test plan
Test parameters: `RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `RETRY_MAX`=2, `SETTLE_CYCLES`=6.
- **Nominal bring-up**: release `rst`, raise `pll_lock_i` 10 cycles later and hold it. Expect `pll_reset_o` high for 4 cycles; `clk_ready_o`=1 and `sys_rst_o`=0 exactly 11 cycles after the lock rise; `fault_o`=0.
- **Lock glitch in STABLE**: lock high for 5 cycles, low for 1, then high. Expect no ready at the first window; ready 11 cycles after the second rise; `pll_reset_o` never reasserted.
- **Timeout/retry/fault**: hold lock low. Expect 3 `pll_reset_o` pulses, then `fault_o`=1 with `pll_reset_o` stuck high. Lock rising afterwards has no effect. Pulsing `rst` clears everything.
- **Phase shift**: in READY, hold `ps_req_i`=1 with `ps_val_i`=4'h5. Expect `pll_psda_o`=5 after 1 cycle, a single `ps_ack_o` 7 cycles later, and `clk_ready_o` held at 1 throughout.
- **Lock loss during settle**: drop lock 2 cycles into PS_SETTLE. Expect no ack; `lock_loss_o` pulse, `sys_rst_o`=1 and `pll_reset_o`=1 after 3 cycles; `pll_psda_o` stays 5; recovery to READY without touching the retry count.
- **Mid-operation reset**: assert `rst` in PS_SETTLE. Next edge: `pll_psda_o`=0, `pll_reset_o`=1, `clk_ready_o`=0, `sys_rst_o`=1, `pll_dutyda_o`=4'b1000.
